// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Raster bundle published by vga_timing_gen. The timing
//               generator drives it through the master modport; sprite and
//               menu renderers, the sync encoder and game-pacing logic read
//               it through the slave modport.
//   DrawX        [9:0] current horizontal count
//   DrawY        [9:0] current vertical count
//   hs                 horizontal sync, active low
//   vs                 vertical sync, active low
//   blank              1 = visible pixel, 0 = blanking interval
//   frame_start        one-cycle pulse at (0,0) after a frame wrap
//   vblank_start       one-cycle pulse at (0,V_VISIBLE)
//   frame_count  [7:0] frames completed, modulo 256
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       frame_start;
    logic       vblank_start;
    logic [7:0] frame_count;

    modport master (
        output DrawX,
        output DrawY,
        output hs,
        output vs,
        output blank,
        output frame_start,
        output vblank_start,
        output frame_count
    );

    modport slave (
        input DrawX,
        input DrawY,
        input hs,
        input vs,
        input blank,
        input frame_start,
        input vblank_start,
        input frame_count
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator (640x480 @ 60 Hz by default).
//               Keeps horizontal/vertical pixel counters, decodes the sync
//               pulses, the active-video qualifier and the frame-level
//               strobes, and counts completed frames.
// Ports       :
//   vga_clk   in   pixel clock, all logic on the rising edge
//   reset_n   in   asynchronous active-low reset
//   vga       master modport of vga_timing_gen_if (DrawX, DrawY, hs, vs,
//             blank, frame_start, vblank_start, frame_count)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    vga_timing_gen_if.master  vga
);

    // ------------------------------------------------------------------
    // Derived 10-bit compare constants
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] c_h_last     = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_v_last     = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_h_vis      = 10'(H_VISIBLE);
    localparam logic [9:0] c_v_vis      = 10'(V_VISIBLE);
    localparam logic [9:0] c_hs_start   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] c_hs_end     = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] c_vs_start   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] c_vs_end     = 10'(V_VISIBLE + V_FP + V_SYNC);

    // ------------------------------------------------------------------
    // Start-up control: the first edge after reset release only arms the
    // counters, so pixel (0,0) is presented for one full pixel period
    // before the count moves to (1,0).
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    // Registered raster state; every output is one of these flops.
    logic [9:0] r_hc;
    logic [9:0] r_vc;
    logic       r_hs;
    logic       r_vs;
    logic       r_blank;
    logic       r_frame_start;
    logic       r_vblank_start;
    logic [7:0] r_frame_count;

    // Next-state values. All decodes are taken from the next counter
    // values so the registered strobes line up with the registered
    // counters in the same cycle (no relative skew).
    logic [9:0] w_hc_next;
    logic [9:0] w_vc_next;
    logic       w_line_end;
    logic       w_frame_end;
    logic       w_line_wrap;
    logic       w_frame_wrap;
    logic       w_hs_next;
    logic       w_vs_next;
    logic       w_blank_next;
    logic       w_vblank_start_next;
    logic [7:0] w_frame_count_next;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and decode logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next        = ST_RUN;
        w_hc_next           = r_hc;
        w_vc_next           = r_vc;
        w_line_wrap         = 1'b0;
        w_frame_wrap        = 1'b0;

        // ">=" rather than "==" keeps the counters bounded even if a
        // value outside the raster ever appeared.
        w_line_end          = (r_hc >= c_h_last);
        w_frame_end         = w_line_end && (r_vc >= c_v_last);

        if (r_state == ST_RUN) begin
            w_line_wrap  = w_line_end;
            w_frame_wrap = w_frame_end;
            if (w_line_end) begin
                w_hc_next = 10'd0;
                if (r_vc >= c_v_last) begin
                    w_vc_next = 10'd0;
                end else begin
                    w_vc_next = r_vc + 10'd1;
                end
            end else begin
                w_hc_next = r_hc + 10'd1;
            end
        end

        // vc only moves on a line wrap, so vs can only change at hc=0.
        w_hs_next           = !((w_hc_next >= c_hs_start) && (w_hc_next < c_hs_end));
        w_vs_next           = !((w_vc_next >= c_vs_start) && (w_vc_next < c_vs_end));
        w_blank_next        = (w_hc_next < c_h_vis) && (w_vc_next < c_v_vis);

        // Qualified by a genuine line wrap so the held (0,0) start-up
        // cycle can never produce a strobe.
        w_vblank_start_next = w_line_wrap && (w_vc_next == c_v_vis);
        w_frame_count_next  = w_frame_wrap ? (r_frame_count + 8'd1) : r_frame_count;
    end

    // ------------------------------------------------------------------
    // Raster registers
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hc           <= 10'd0;
            r_vc           <= 10'd0;
            r_hs           <= 1'b1;
            r_vs           <= 1'b1;
            r_blank        <= 1'b1;
            r_frame_start  <= 1'b0;
            r_vblank_start <= 1'b0;
            r_frame_count  <= 8'd0;
        end else begin
            r_hc           <= w_hc_next;
            r_vc           <= w_vc_next;
            r_hs           <= w_hs_next;
            r_vs           <= w_vs_next;
            r_blank        <= w_blank_next;
            r_frame_start  <= w_frame_wrap;
            r_vblank_start <= w_vblank_start_next;
            r_frame_count  <= w_frame_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign vga.DrawX        = r_hc;
    assign vga.DrawY        = r_vc;
    assign vga.hs           = r_hs;
    assign vga.vs           = r_vs;
    assign vga.blank        = r_blank;
    assign vga.frame_start  = r_frame_start;
    assign vga.vblank_start = r_vblank_start;
    assign vga.frame_count  = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. Three instances share
//               one clock and reset: the default 640x480 raster, a half-scale
//               raster (400 clocks per line) and a tiny 16x10 raster used for
//               whole-frame and frame-counter behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic vga_clk;
    logic reset_n;

    vga_timing_gen_if vga_def  ();
    vga_timing_gen_if vga_tiny ();
    vga_timing_gen_if vga_half ();

    // 800 x 525 default raster
    vga_timing_gen u_def (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .vga     (vga_def)
    );

    // 16 x 10 raster: hs low hc 10..12, vs low vc 7..8, 160 clocks per frame
    vga_timing_gen #(
        .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_VISIBLE (6), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) u_tiny (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .vga     (vga_tiny)
    );

    // Half-scale raster: 400 x 262, hs low hc 328..375
    vga_timing_gen #(
        .H_VISIBLE (320), .H_FP (8), .H_SYNC (48), .H_BP (24),
        .V_VISIBLE (240), .V_FP (5), .V_SYNC (1), .V_BP (16)
    ) u_half (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .vga     (vga_half)
    );

    initial vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    int n_checks = 0;
    int n_errors = 0;
    int k        = 0;   // rising edges since the last reset release

    typedef struct {
        int k;
        int inst;   // 0 default, 1 tiny, 2 half
        int x;
        int y;
        int hs;
        int vs;
        int bl;
        int fs;
        int vbs;
        int fc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int k_i, int inst, int x, int y, int hs, int vs,
                                int bl, int fs, int vbs, int fc);
        vec_t v;
        v.k = k_i; v.inst = inst; v.x = x; v.y = y; v.hs = hs; v.vs = vs;
        v.bl = bl; v.fs = fs; v.vbs = vbs; v.fc = fc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic read_out(input int inst, output logic [31:0] x, output logic [31:0] y,
                            output logic [31:0] hs, output logic [31:0] vs,
                            output logic [31:0] bl, output logic [31:0] fs,
                            output logic [31:0] vbs, output logic [31:0] fc);
        case (inst)
            1: begin
                x = 32'(vga_tiny.DrawX); y = 32'(vga_tiny.DrawY);
                hs = 32'(vga_tiny.hs); vs = 32'(vga_tiny.vs); bl = 32'(vga_tiny.blank);
                fs = 32'(vga_tiny.frame_start); vbs = 32'(vga_tiny.vblank_start);
                fc = 32'(vga_tiny.frame_count);
            end
            2: begin
                x = 32'(vga_half.DrawX); y = 32'(vga_half.DrawY);
                hs = 32'(vga_half.hs); vs = 32'(vga_half.vs); bl = 32'(vga_half.blank);
                fs = 32'(vga_half.frame_start); vbs = 32'(vga_half.vblank_start);
                fc = 32'(vga_half.frame_count);
            end
            default: begin
                x = 32'(vga_def.DrawX); y = 32'(vga_def.DrawY);
                hs = 32'(vga_def.hs); vs = 32'(vga_def.vs); bl = 32'(vga_def.blank);
                fs = 32'(vga_def.frame_start); vbs = 32'(vga_def.vblank_start);
                fc = 32'(vga_def.frame_count);
            end
        endcase
    endtask

    task automatic chk_vec(input string tag, input vec_t v);
        logic [31:0] x, y, hs, vs, bl, fs, vbs, fc;
        read_out(v.inst, x, y, hs, vs, bl, fs, vbs, fc);
        chk({tag, ".DrawX"},        x,   32'(v.x));
        chk({tag, ".DrawY"},        y,   32'(v.y));
        chk({tag, ".hs"},           hs,  32'(v.hs));
        chk({tag, ".vs"},           vs,  32'(v.vs));
        chk({tag, ".blank"},        bl,  32'(v.bl));
        chk({tag, ".frame_start"},  fs,  32'(v.fs));
        chk({tag, ".vblank_start"}, vbs, 32'(v.vbs));
        chk({tag, ".frame_count"},  fc,  32'(v.fc));
    endtask

    // One rising edge, then sample on the following falling edge.
    task automatic step();
        @(posedge vga_clk);
        k++;
        @(negedge vga_clk);
    endtask

    // Global time bound
    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "time limit");
    end

    initial begin
        int cnt;
        int vb;
        int fc0;

        // inst, (x,y), hs, vs, blank, frame_start, vblank_start, frame_count
        vecs.push_back(mk(   1, 0,   0, 0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(   1, 1,   0, 0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(   1, 2,   0, 0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(   2, 0,   1, 0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(   2, 1,   1, 0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(  11, 1,  10, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(  13, 1,  12, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(  14, 1,  13, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(  97, 1,   0, 6, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(  98, 1,   1, 6, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk( 113, 1,   0, 7, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk( 144, 1,  15, 8, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk( 145, 1,   0, 9, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk( 160, 1,  15, 9, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk( 161, 1,   0, 0, 1, 1, 1, 1, 0, 1));
        vecs.push_back(mk( 162, 1,   1, 0, 1, 1, 1, 0, 0, 1));
        vecs.push_back(mk( 321, 2, 320, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk( 328, 2, 327, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk( 329, 2, 328, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk( 376, 2, 375, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk( 377, 2, 376, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk( 400, 2, 399, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk( 401, 2,   0, 1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk( 640, 0, 639, 0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk( 641, 0, 640, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk( 641, 1,   0, 0, 1, 1, 1, 1, 0, 4));
        vecs.push_back(mk( 656, 0, 655, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk( 657, 0, 656, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk( 752, 0, 751, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk( 753, 0, 752, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk( 800, 0, 799, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk( 801, 0,   0, 1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk( 801, 1,   0, 0, 1, 1, 1, 1, 0, 5));
        vecs.push_back(mk(1441, 0, 640, 1, 1, 1, 0, 0, 0, 0));

        // ---------------- reset hold and release ----------------
        reset_n = 1'b0;
        repeat (5) @(posedge vga_clk);
        @(negedge vga_clk);
        chk_vec("rst_def",  mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        chk_vec("rst_tiny", mk(0, 1, 0, 0, 1, 1, 1, 0, 0, 0));
        reset_n = 1'b1;
        k = 0;

        // ---------------- table-driven vectors ----------------
        foreach (vecs[i]) begin
            if (k < vecs[i].k) begin
                while (k < vecs[i].k) begin
                    @(posedge vga_clk);
                    k++;
                end
                @(negedge vga_clk);
            end
            chk_vec($sformatf("vec%0d_k%0d", i, vecs[i].k), vecs[i]);
        end

        // ---------------- frame counter over 256 tiny frames ----------------
        cnt = 0;
        while (vga_tiny.frame_start !== 1'b1 && cnt < 200) begin
            step();
            cnt++;
        end
        chk("sync_frame_start", 32'(vga_tiny.frame_start), 32'd1);
        chk("sync_frame_count", 32'(vga_tiny.frame_count), 32'(((k - 1) / 160) % 256));
        fc0 = int'(vga_tiny.frame_count);
        for (int f = 1; f <= 256; f++) begin
            cnt = 0;
            vb  = 0;
            do begin
                step();
                cnt++;
                if (vga_tiny.vblank_start === 1'b1) begin
                    vb++;
                    chk($sformatf("f%0d_vbs_x", f), 32'(vga_tiny.DrawX), 32'd0);
                    chk($sformatf("f%0d_vbs_y", f), 32'(vga_tiny.DrawY), 32'd6);
                end
            end while (vga_tiny.frame_start !== 1'b1 && cnt < 200);
            chk($sformatf("f%0d_period", f), 32'(cnt), 32'd160);
            chk($sformatf("f%0d_count", f), 32'(vga_tiny.frame_count), 32'((fc0 + f) % 256));
            chk($sformatf("f%0d_vbs_once", f), 32'(vb), 32'd1);
            chk($sformatf("f%0d_pos", f), {12'd0, vga_tiny.DrawY, vga_tiny.DrawX}, 32'd0);
        end
        chk("fc_after_256", 32'(vga_tiny.frame_count), 32'(((k - 1) / 160) % 256));

        // ---------------- mid-frame asynchronous reset ----------------
        cnt = 0;
        while (vga_def.DrawX !== 10'd300 && cnt < 1000) begin
            step();
            cnt++;
        end
        chk("mid_pos_x", 32'(vga_def.DrawX), 32'd300);
        reset_n = 1'b0;
        #1;
        chk_vec("mid_rst_def",  mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        chk_vec("mid_rst_tiny", mk(0, 1, 0, 0, 1, 1, 1, 0, 0, 0));
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        reset_n = 1'b1;
        k = 0;
        step();
        chk_vec("mid_k1_def",  mk(1, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        chk_vec("mid_k1_tiny", mk(1, 1, 0, 0, 1, 1, 1, 0, 0, 0));
        step();
        chk_vec("mid_k2_def",  mk(2, 0, 1, 0, 1, 1, 1, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480 @ 60 Hz VGA raster for the display path: horizontal/vertical pixel counters, sync pulses, the active-video `blank` qualifier, and frame-level strobes. Its `DrawX`, `DrawY` and `blank` outputs drive every sprite/menu renderer, which uses them to address its ROMs and gate colour output. Sync outputs go straight to the VGA/HDMI encoder. Frame strobes pace game logic.

## Interface
- `H_VISIBLE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_VISIBLE`, 480, active lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `vga_clk  in  1  pixel clock, 25 MHz; all logic on rising edge`
- `reset_n  in  1  asynchronous, active-low reset`
- `DrawX  out  10  current horizontal count, 0..H_TOTAL-1 (H_TOTAL=800)`
- `DrawY  out  10  current vertical count, 0..V_TOTAL-1 (V_TOTAL=525)`
- `hs  out  1  horizontal sync, active low`
- `vs  out  1  vertical sync, active low`
- `blank  out  1  1 = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE), 0 = blanking`
- `frame_start  out  1  one-cycle pulse at (0,0) after a frame wrap`
- `vblank_start  out  1  one-cycle pulse at (0,V_VISIBLE)`
- `frame_count  out  8  frames completed, mod 256`

## Operation
- One clock (`vga_clk`); reset asynchronous, active-low (`reset_n`).
- Horizontal counter hc: increments every clock; at H_TOTAL-1 wraps to 0 and advances vertical counter vc.
- vc: at V_TOTAL-1 with hc wrap, wraps to 0 and frame_count increments (8-bit, 255 -> 0).
- `DrawX`=hc, `DrawY`=vc, all registered.
- `hs`=0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751).
- `vs`=0 iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491); vs changes only at hc=0 boundaries.
- `frame_start`=1 for exactly the cycle where (hc,vc)=(0,0) reached by wrap; never on the first cycle after reset.
- `vblank_start`=1 for exactly the cycle where (hc,vc)=(0,480).
- All counter widths 10 bits; compare constants derived from parameters; no overflow past H_TOTAL-1/V_TOTAL-1.

## Timing
- Every output is a flop; all outputs correspond to the same (hc,vc) in the same cycle, with zero relative skew. Decode of hs/vs/blank/strobes computed from next-state counter values.
- Reset values: DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_start=0, vblank_start=0, frame_count=0.
- Reset assertion mid-frame: all outputs take reset values immediately (asynchronous), no partial pulse completes.
- After deassertion: first rising edge holds (0,0); the count becomes (1,0) on the second edge. (0,0) is displayed for one full pixel period.
- Line = 800 clocks; frame = 420000 clocks; frame_start period exactly 420000 clocks.
- Line wrap: cycle N is (799,y), cycle N+1 is (0,y+1). Frame wrap: (799,524) -> (0,0) with frame_start=1 and frame_count+1 in that same cycle.
- Consumers with a 1-cycle ROM latency compensate on their side; this block adds no pipeline delay.

## Test plan
- Reset release: hold reset_n=0 for 5 clocks, release -> outputs at reset values, DrawX=0 for 2 edges, DrawX=1 on the following cycle, frame_start stays 0.
- Line timing: run 800 clocks -> hs falls at DrawX=656, rises at DrawX=752 (96 clocks low), blank=0 for DrawX 640..799, wrap to DrawX=0, DrawY=1.
- Frame timing: run 420000 clocks -> vs low only while DrawY=490..491 (1600 clocks), blank=0 for DrawY>=480, vblank_start exactly once at (0,480), frame_start exactly once at (0,0) after (799,524).
- Frame counter wrap: run 256 frames -> frame_count goes 0..255 then 0; one increment per frame_start.
- Mid-frame reset: assert reset_n=0 at (300,200) between clock edges -> outputs go to reset values before the next edge; resume from (0,0) with no frame_start pulse.
- Parameter override: H_VISIBLE=320, V_VISIBLE=240, porches and syncs scaled by half -> H_TOTAL=400, V_TOTAL=262/263-consistent wrap, sync windows track the parameters.
